fp_mult_seq: RTL and testbench

- Sequential IEEE-754 single-precision multiplier datapath; sits directly upstream of the multiply exception stage.
- Produces the raw rounded result z_calc and the overflow/underflow/inexact indications.
- Forwards the original operands and rounding mode so the exception stage can classify zero/inf inputs.
- Significand product computed by an iterative 24-cycle shift-add engine, followed by one normalise/round cycle; valid/ready handshakes on both sides.

---
 rtl/fp_mult_seq_pkg.sv | 44 ++++
 rtl/fp_round_norm.sv | 57 +++++
 rtl/fp_mult_seq.sv | 168 ++++++++++++++++
 tb/tb_fp_mult_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_seq_pkg.sv
// Shared types and constants for the sequential binary32 multiplier.
//   round_t : rounding mode carried alongside the operands
//   state_t : control FSM encoding
//   round_inc() : rounding-increment decision for one mantissa
package fp_mult_seq_pkg;

   localparam int MANT_W   = 24;
   localparam int PROD_W   = 2 * MANT_W;
   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;

   typedef enum logic [2:0] {
      IEEE_near = 3'd0,
      IEEE_zero = 3'd1,
      IEEE_pinf = 3'd2,
      IEEE_ninf = 3'd3,
      near_up   = 3'd4,
      away_zero = 3'd5
   } round_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_NORM = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic round_inc(input round_t rnd, input logic sign,
                                      input logic lsb, input logic guard,
                                      input logic sticky);
      logic inc;
      case (rnd)
         IEEE_near: inc = guard & (sticky | lsb);
         IEEE_zero: inc = 1'b0;
         IEEE_pinf: inc = (guard | sticky) & ~sign;
         IEEE_ninf: inc = (guard | sticky) & sign;
         near_up:   inc = (guard & ~sign) | (guard & sticky);
         away_zero: inc = guard | sticky;
         default:   inc = 1'b0;
      endcase
      return inc;
   endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Normalise/round stage for the binary32 multiplier (purely combinational).
//   prod_i     : 48-bit significand product
//   exp_sum_i  : signed biased exponent ea+eb-bias
//   sign_i     : result sign
//   rnd_i      : rounding mode
//   z_calc_o   : {sign, exp[7:0], frac[22:0]} after rounding
//   overflow_o / underflow_o : post-round exponent >= 255 / <= 0
//   inexact_o  : guard|sticky before rounding
module fp_round_norm
   import fp_mult_seq_pkg::*;
(
   input  logic [47:0]        prod_i,
   input  logic signed [9:0]  exp_sum_i,
   input  logic               sign_i,
   input  round_t             rnd_i,
   output logic [31:0]        z_calc_o,
   output logic               overflow_o,
   output logic               underflow_o,
   output logic               inexact_o
);

   logic [22:0]        mant;
   logic               guard;
   logic               sticky;
   logic               inc;
   logic [23:0]        mant_r;
   logic signed [9:0]  exp_n;
   logic signed [9:0]  exp_r;

   always_comb begin
      if (prod_i[47]) begin
         mant   = prod_i[46:24];
         guard  = prod_i[23];
         sticky = |prod_i[22:0];
         exp_n  = exp_sum_i + 10'sd1;
      end else begin
         mant   = prod_i[45:23];
         guard  = prod_i[22];
         sticky = |prod_i[21:0];
         exp_n  = exp_sum_i;
      end

      inc    = round_inc(rnd_i, sign_i, mant[0], guard, sticky);
      mant_r = {1'b0, mant} + {23'd0, inc};

      // A carry out of the 23-bit field leaves the low bits at zero already,
      // so only the exponent needs bumping.
      exp_r = mant_r[23] ? exp_n + 10'sd1 : exp_n;

      // Exponent field is truncated; the exception stage overrides on flags.
      z_calc_o    = {sign_i, exp_r[7:0], mant_r[22:0]};
      overflow_o  = (exp_r >= 10'sd255);
      underflow_o = (exp_r <= 10'sd0);
      inexact_o   = guard | sticky;
   end

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential binary32 multiplier: 24-cycle shift-add significand engine
// followed by one normalise/round cycle, with valid/ready on both sides.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand handshake (a, b, rnd)
//   out_valid/out_ready : result handshake
//   a_q, b_q, rnd_q     : captured operands, forwarded to the exception stage
//   z_calc              : rounded result
//   overflow, underflow, inexact : result flags
//
// state   | meaning
// IDLE    | waiting for operands, in_ready=1
// MULT    | one shift-add iteration per cycle, 24 cycles
// NORM    | normalise, round, register result and flags
// DONE    | out_valid=1, outputs held until out_ready
module fp_mult_seq
   import fp_mult_seq_pkg::*;
#(
   parameter int MANT_W   = 24,
   parameter int EXP_BIAS = 127
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  round_t      rnd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] a_q,
   output logic [31:0] b_q,
   output round_t      rnd_q,
   output logic [31:0] z_calc,
   output logic        overflow,
   output logic        underflow,
   output logic        inexact
);

   state_t                  state_q, state_d;
   logic [31:0]             a_d, b_d;
   round_t                  rnd_d;
   logic [MANT_W-1:0]       mcand_q, mcand_d;
   logic [MANT_W-1:0]       mplier_q, mplier_d;
   logic [2*MANT_W-1:0]     prod_q, prod_d;
   logic [4:0]              cnt_q, cnt_d;
   logic [31:0]             z_calc_q, z_calc_d;
   logic                    ovf_q, ovf_d;
   logic                    unf_q, unf_d;
   logic                    inx_q, inx_d;
   logic [MANT_W:0]         add_sum;

   logic [9:0]              exp_sum_u;
   logic [31:0]             rn_z;
   logic                    rn_ovf, rn_unf, rn_inx;

   assign exp_sum_u = {2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - 10'(EXP_BIAS);

   fp_round_norm u_round_norm (
      .prod_i      (prod_q),
      .exp_sum_i   ($signed(exp_sum_u)),
      .sign_i      (a_q[31] ^ b_q[31]),
      .rnd_i       (rnd_q),
      .z_calc_o    (rn_z),
      .overflow_o  (rn_ovf),
      .underflow_o (rn_unf),
      .inexact_o   (rn_inx)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      rnd_d    = rnd_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      z_calc_d = z_calc_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      inx_d    = inx_q;
      add_sum  = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               rnd_d    = rnd;
               mcand_d  = {|a[30:23], a[22:0]};
               mplier_d = {|b[30:23], b[22:0]};
               prod_d   = '0;
               cnt_d    = '0;
               state_d  = ST_MULT;
            end
         end
         ST_MULT: begin
            // Add into the upper half, then shift the whole product right;
            // the add carry becomes the new MSB.
            add_sum  = {1'b0, prod_q[2*MANT_W-1:MANT_W]}
                     + (mplier_q[0] ? {1'b0, mcand_q} : '0);
            prod_d   = {add_sum, prod_q[MANT_W-1:1]};
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'(MANT_W - 1)) begin
               state_d = ST_NORM;
            end
         end
         ST_NORM: begin
            z_calc_d = rn_z;
            ovf_d    = rn_ovf;
            unf_d    = rn_unf;
            inx_d    = rn_inx;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         rnd_q    <= IEEE_near;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         z_calc_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         inx_q    <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         rnd_q    <= rnd_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         z_calc_q <= z_calc_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         inx_q    <= inx_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign z_calc    = z_calc_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign inexact   = inx_q;

endmodule

// File: tb/tb_fp_mult_seq.sv
module tb_fp_mult_seq;
   import fp_mult_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   round_t      rnd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] a_q;
   logic [31:0] b_q;
   round_t      rnd_q;
   logic [31:0] z_calc;
   logic        overflow;
   logic        underflow;
   logic        inexact;

   int n_checks = 0;
   int n_fail   = 0;
   int acc_cnt  = 0;

   fp_mult_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .rnd       (rnd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_q       (a_q),
      .b_q       (b_q),
      .rnd_q     (rnd_q),
      .z_calc    (z_calc),
      .overflow  (overflow),
      .underflow (underflow),
      .inexact   (inexact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (in_valid && in_ready && !rst) acc_cnt++;
   end

   // Reference: exact integer product, then round by comparing the discarded
   // remainder against the half-ulp point.
   function automatic void ref_mult(input logic [31:0] ra, input logic [31:0] rb,
                                    input round_t rr, output logic [31:0] z,
                                    output logic ov, output logic un, output logic ix);
      longint unsigned ma, mb, p, rem, half, frac;
      int e;
      bit s, up;
      s  = ra[31] ^ rb[31];
      ma = longint'(ra[22:0]) + ((ra[30:23] != 0) ? 64'd8388608 : 64'd0);
      mb = longint'(rb[22:0]) + ((rb[30:23] != 0) ? 64'd8388608 : 64'd0);
      p  = ma * mb;
      e  = int'(ra[30:23]) + int'(rb[30:23]) - 127;
      if (p >= (64'd1 << 47)) begin
         frac = (p >> 24) % (64'd1 << 23);
         rem  = p % (64'd1 << 24);
         half = 64'd1 << 23;
         e    = e + 1;
      end else begin
         frac = (p >> 23) % (64'd1 << 23);
         rem  = p % (64'd1 << 23);
         half = 64'd1 << 22;
      end
      case (rr)
         IEEE_near: up = (rem > half) || (rem == half && frac[0]);
         IEEE_zero: up = 1'b0;
         IEEE_pinf: up = (rem != 0) && !s;
         IEEE_ninf: up = (rem != 0) && s;
         near_up:   up = (rem > half) || (rem == half && !s);
         away_zero: up = (rem != 0);
         default:   up = 1'b0;
      endcase
      frac = frac + (up ? 64'd1 : 64'd0);
      if (frac == (64'd1 << 23)) begin
         frac = 0;
         e    = e + 1;
      end
      ov = (e >= 255);
      un = (e <= 0);
      ix = (rem != 0);
      z  = {s, 8'(e), 23'(frac)};
   endfunction

   // Drives one operation and waits (bounded) for out_valid; lat=-1 on timeout.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_op,
                         input round_t tr, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      a = ta;
      b = tb_op;
      rnd = tr;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #23;
      n_checks++;
      if ({in_ready, out_valid, z_calc, overflow, underflow, inexact, a_q, b_q} !==
          {1'b1, 1'b0, 32'd0, 3'b000, 64'd0}) begin
         n_fail++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b z=%h flags=%b%b%b a_q=%h b_q=%h, want 1 0 0 000 0 0",
                  in_ready, out_valid, z_calc, overflow, underflow, inexact, a_q, b_q);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      int lat;
      logic [31:0] va [6];
      logic [31:0] vb [6];
      round_t      vr [6];
      logic [31:0] vz [6];
      logic [2:0]  vf [6];
      va[0]=32'h3FC00000; vb[0]=32'h40000000; vr[0]=IEEE_near; vz[0]=32'h40400000; vf[0]=3'b000;
      va[1]=32'h3F800001; vb[1]=32'h3F800001; vr[1]=IEEE_near; vz[1]=32'h3F800002; vf[1]=3'b001;
      va[2]=32'h3F800001; vb[2]=32'h3F800001; vr[2]=IEEE_pinf; vz[2]=32'h3F800003; vf[2]=3'b001;
      va[3]=32'h3F800001; vb[3]=32'h3F800001; vr[3]=IEEE_zero; vz[3]=32'h3F800002; vf[3]=3'b001;
      va[4]=32'h7F000000; vb[4]=32'h40000000; vr[4]=IEEE_near; vz[4]=32'h7F800000; vf[4]=3'b100;
      va[5]=32'h00800000; vb[5]=32'h3F000000; vr[5]=IEEE_near; vz[5]=32'h00000000; vf[5]=3'b010;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], vr[i], lat);
         n_checks++;
         if (lat !== 25) begin
            n_fail++;
            $display("FAIL latency[%0d]: got %0d cycles, want 25", i, lat);
         end
         n_checks++;
         if (z_calc !== vz[i]) begin
            n_fail++;
            $display("FAIL z_calc[%0d]: got %h, want %h", i, z_calc, vz[i]);
         end
         n_checks++;
         if ({overflow, underflow, inexact} !== vf[i]) begin
            n_fail++;
            $display("FAIL flags[%0d]: got ovf/unf/inx=%b, want %b", i,
                     {overflow, underflow, inexact}, vf[i]);
         end
         release_out();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int base;
      logic [101:0] snap;
      base = acc_cnt;
      @(negedge clk);
      a = 32'h40490FDB;
      b = 32'hC0000000;
      rnd = away_zero;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Stray operands during MULT must be ignored.
      repeat (3) @(negedge clk);
      a = 32'h12345678;
      b = 32'h3F800000;
      in_valid = 1'b1;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      n_checks++;
      if (!out_valid) begin
         n_fail++;
         $display("FAIL bp_valid: out_valid never rose within 60 cycles");
      end
      snap = {out_valid, z_calc, a_q, b_q, overflow, underflow, inexact, in_ready, 1'b0};
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({out_valid, z_calc, a_q, b_q, overflow, underflow, inexact, in_ready, 1'b0} !== snap ||
             in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: valid=%b z=%h in_ready=%b, want held z=%h in_ready=0",
                     c, out_valid, z_calc, in_ready, snap[100:69]);
         end
      end
      n_checks++;
      if (a_q !== 32'h40490FDB || b_q !== 32'hC0000000) begin
         n_fail++;
         $display("FAIL bp_operands: a_q=%h b_q=%h, want 40490fdb c0000000", a_q, b_q);
      end
      release_out();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      n_checks++;
      if (acc_cnt - base !== 1) begin
         n_fail++;
         $display("FAIL bp_accepts: got %0d accepts, want 1", acc_cnt - base);
      end
   endtask

   task automatic test_reset_mid_op();
      int lat;
      bit seen;
      @(negedge clk);
      a = 32'h40400000;
      b = 32'h40400000;
      rnd = IEEE_near;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_ready: in_ready=%b, want 1", in_ready);
      end
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1;
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL rst_mid_valid: out_valid=1 seen after reset, want 0");
      end
      run_op(32'h3F800000, 32'h3F800000, IEEE_near, lat);
      n_checks++;
      if (lat !== 25 || z_calc !== 32'h3F800000) begin
         n_fail++;
         $display("FAIL rst_mid_next: lat=%0d z=%h, want 25 3f800000", lat, z_calc);
      end
      release_out();
   endtask

   task automatic test_random();
      int lat;
      logic [31:0] ra, rb, ez;
      logic eov, eun, eix;
      round_t rr;
      for (int i = 0; i < 1200; i++) begin
         case ($urandom_range(0, 3))
            0: begin ra = $urandom; rb = $urandom; end
            1, 2: begin
               ra = {1'($urandom), 8'($urandom_range(90, 160)), 23'($urandom)};
               rb = {1'($urandom), 8'($urandom_range(90, 160)), 23'($urandom)};
            end
            default: begin
               ra = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom) & 23'h7FF800};
               rb = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom) & 23'h7FF800};
            end
         endcase
         rr = round_t'($urandom_range(0, 5));
         ref_mult(ra, rb, rr, ez, eov, eun, eix);
         run_op(ra, rb, rr, lat);
         n_checks++;
         if (lat !== 25 || z_calc !== ez || {overflow, underflow, inexact} !== {eov, eun, eix}) begin
            n_fail++;
            $display("FAIL rand_result[%0d]: a=%h b=%h rnd=%0d lat=%0d z=%h flags=%b, want 25 %h %b",
                     i, ra, rb, rr, lat, z_calc, {overflow, underflow, inexact}, ez, {eov, eun, eix});
         end
         n_checks++;
         if (a_q !== ra || b_q !== rb || rnd_q !== rr) begin
            n_fail++;
            $display("FAIL rand_fwd[%0d]: a_q=%h b_q=%h rnd_q=%0d, want %h %h %0d",
                     i, a_q, b_q, rnd_q, ra, rb, rr);
         end
         release_out();
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a   = '0;
      b   = '0;
      rnd = IEEE_near;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_op();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
